lcd_bus_receiver: RTL and testbench
===================================

// Module: lcd_bus_receiver
// PURPOSE
// - Responder end of the HD44780-style LCD write bus (LCD_EN/LCD_RS/LCD_DATA) driven by our LCD writer.
// - Captures each EN strobe, decodes commands/data and maintains a 2x16 character frame buffer.
// - Buffer is readable per cell. Busy/overrun reporting enables self-checking of the writer in sim and on FPGA.
// PARAMETERS
// - SYNC_STAGES   2      flops per synchronizer on LCD_EN/LCD_RS/LCD_DATA (min 2)
// - BUSY_CYCLES   2000   CLOCK_50 cycles busy after any non-clear strobe (40us @ 50MHz)
// - CLEAR_CYCLES  82000  cycles busy after clear command (1.64ms); must be >= 32
// PORTS
// - CLOCK_50       in   1   single system clock, all logic rising-edge
// - Reset          in   1   asynchronous, active-low reset
// - LCD_EN         in   1   write strobe from writer, asynchronous to CLOCK_50 domain assumptions
// - LCD_RS         in   1   0=command, 1=data
// - LCD_DATA       in   8   command/character byte
// - rd_row         in   1   readback row
// - rd_col         in   4   readback column
// - rd_char        out  8   buffer[rd_row][rd_col], registered
// - cursor         out  5   {row,col} of next data write
// - display_on     out  1   D bit of last display-control command
// - busy           out  1   high while a strobe is being processed
// - overrun        out  1   sticky: strobe arrived while busy
// - addr_err       out  1   sticky: set-DDRAM address outside 0x00-0x0F/0x40-0x4F
// - write_count    out  16  accepted strobes, saturates at 0xFFFF
// BEHAVIOUR
// - Reset (async, Reset=0): all 32 cells=0x20, cursor=0, increment mode, display_on=0, busy=0, overrun=0, addr_err=0, write_count=0, rd_char=0x20. Reset mid-clear/mid-busy aborts immediately.
// - Inputs pass through SYNC_STAGES flops. RS/DATA are delayed identically to EN.
// - Strobe = synced EN 1->0. Sampled RS/DATA = values from the last cycle synced EN was 1.
// - Decode/update occurs the cycle after the strobe; busy rises the same cycle.
// - Strobe while busy=1: ignored (no state change, not counted); overrun<=1.
// - Accepted strobe: write_count+1 (saturating). Decode in priority order:
//   - RS=1: buffer[cursor]<=DATA, cursor advances per entry mode.
//   - RS=0, DATA[7]=1: set address. 0x00-0x0F -> row0; 0x40-0x4F -> row1; col=DATA[3:0]. Otherwise cursor unchanged, addr_err<=1.
//   - RS=0, DATA[7:5]=001: function set; accepted, no state.
//   - RS=0, DATA[7:3]=00001: display_on<=DATA[2].
//   - RS=0, DATA[7:2]=000001: entry mode; increment=DATA[1]; shift bit ignored.
//   - RS=0, DATA[7:1]=0000001: return home, cursor=0.
//   - RS=0, DATA=0x01: clear. Cursor=0, increment mode set, cells written 0x20 one per cycle (index 0..31, 32 cycles).
//   - RS=0, DATA=0x00: accepted no-op.
// - Cursor wrap:
//   - increment: (0,15)->(1,0); (1,15)->(0,0)
//   - decrement: (0,0)->(1,15); (1,0)->(0,15)
// - Busy timing: busy held exactly BUSY_CYCLES cycles (CLEAR_CYCLES for clear), counted from the decode cycle.
//   Strobe arriving on the last busy cycle is overrun; the next cycle is free.
// - rd_char: 1-cycle latency from rd_row/rd_col. Same-cycle write to the read cell returns the old value.
// - overrun/addr_err clear only on reset.
// TESTING
// - Reset, strobe RS=1 DATA=0x61 ('a') then wait -> cell(0,0)=0x61, cursor=1, write_count=1, busy high exactly BUSY_CYCLES.
// - Set addr 0x4F, write 'x','y' -> (1,15)=0x78, (0,0)=0x79, cursor=(0,1).
// - Write "abcd" at 0, then 0x01 -> 32 cells=0x20 within 32 cycles; cursor=0; busy CLEAR_CYCLES cycles.
// - Second strobe 10 cycles after first -> overrun=1, buffer/cursor/write_count unchanged by second strobe.
// - 0x04 (decrement), addr 0x80, write 'z' -> (0,0)=0x7A, cursor=(1,15). Then addr 0xA0 -> addr_err=1, cursor unchanged.
// - Assert Reset 100 cycles into a clear -> all outputs at reset values next cycle; strobe after release accepted.

Source files
------------

// File: rtl/lcd_bus_receiver.sv
// Responder end of the HD44780-style LCD write bus: synchronizes the writer's strobes,
// decodes commands/data and keeps a readable 2x16 frame buffer with busy/overrun flags.
module lcd_bus_receiver #(
  parameter int SYNC_STAGES  = 2,
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic        CLOCK_50,
  input  logic        Reset,
  input  logic        LCD_EN,
  input  logic        LCD_RS,
  input  logic [7:0]  LCD_DATA,
  input  logic        rd_row,
  input  logic [3:0]  rd_col,
  output logic [7:0]  rd_char,
  output logic [4:0]  cursor,
  output logic        display_on,
  output logic        busy,
  output logic        overrun,
  output logic        addr_err,
  output logic [15:0] write_count
);

  localparam int MAX_CYC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [7:0] BLANK = 8'h20;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (CLEAR_CYCLES < 32) begin : g_bad_clear
    $error("CLEAR_CYCLES must cover the 32-cell clear sweep");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_HOLD
  } state_e;

  // Input synchronizers: RS/DATA ride the same number of stages as EN so they stay aligned.
  logic [SYNC_STAGES-1:0]      en_sync_q;
  logic [SYNC_STAGES-1:0]      rs_sync_q;
  logic [SYNC_STAGES-1:0][7:0] data_sync_q;

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      en_sync_q   <= '0;
      rs_sync_q   <= '0;
      data_sync_q <= '0;
    end else begin
      en_sync_q   <= {en_sync_q[SYNC_STAGES-2:0], LCD_EN};
      rs_sync_q   <= {rs_sync_q[SYNC_STAGES-2:0], LCD_RS};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], LCD_DATA};
    end
  end

  logic       en_s;
  logic       rs_s;
  logic [7:0] data_s;

  assign en_s   = en_sync_q[SYNC_STAGES-1];
  assign rs_s   = rs_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];

  logic       en_prev_q;
  logic       rs_smp_q;
  logic [7:0] data_smp_q;
  logic       strobe;

  // RS/DATA are held from the last cycle EN was high, so they are valid on the falling edge.
  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      en_prev_q  <= 1'b0;
      rs_smp_q   <= 1'b0;
      data_smp_q <= '0;
    end else begin
      en_prev_q <= en_s;
      if (en_s) begin
        rs_smp_q   <= rs_s;
        data_smp_q <= data_s;
      end
    end
  end

  assign strobe = en_prev_q & ~en_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       fill_q, fill_d;
  logic [4:0]       cursor_q, cursor_d;
  logic             inc_q, inc_d;
  logic             disp_q, disp_d;
  logic             ovr_q, ovr_d;
  logic             aerr_q, aerr_d;
  logic [15:0]      wcnt_q, wcnt_d;

  logic             mem_we;
  logic [4:0]       mem_waddr;
  logic [7:0]       mem_wdata;

  // NOTE: every signal gets a default before any branch, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    cursor_d  = cursor_q;
    inc_d     = inc_q;
    disp_d    = disp_q;
    ovr_d     = ovr_q;
    aerr_d    = aerr_q;
    wcnt_d    = wcnt_q;
    mem_we    = 1'b0;
    mem_waddr = cursor_q;
    mem_wdata = data_smp_q;

    if (strobe && (state_q != ST_IDLE)) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (strobe) begin
          wcnt_d  = (wcnt_q == 16'hFFFF) ? wcnt_q : wcnt_q + 16'd1;
          state_d = ST_HOLD;
          cnt_d   = BUSY_LOAD;
          if (rs_smp_q) begin
            mem_we   = 1'b1;
            cursor_d = inc_q ? cursor_q + 5'd1 : cursor_q - 5'd1;
          end else begin
            casez (data_smp_q)
              8'b1???_????: begin
                if (data_smp_q[6:4] == 3'b000) begin
                  cursor_d = {1'b0, data_smp_q[3:0]};
                end else if (data_smp_q[6:4] == 3'b100) begin
                  cursor_d = {1'b1, data_smp_q[3:0]};
                end else begin
                  aerr_d = 1'b1;
                end
              end
              8'b001?_????: ;
              8'b0000_1???: disp_d = data_smp_q[2];
              8'b0000_01??: inc_d = data_smp_q[1];
              8'b0000_001?: cursor_d = '0;
              8'b0000_0001: begin
                cursor_d = '0;
                inc_d    = 1'b1;
                fill_d   = '0;
                state_d  = ST_FILL;
                cnt_d    = CLEAR_LOAD;
              end
              default: ;
            endcase
          end
        end
      end

      // Clear sweep: one blank per cycle while the busy window keeps counting down.
      ST_FILL: begin
        mem_we    = 1'b1;
        mem_waddr = fill_q;
        mem_wdata = BLANK;
        fill_d    = fill_q + 5'd1;
        cnt_d     = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        if (fill_q == 5'd31) begin
          state_d = (cnt_q == '0) ? ST_IDLE : ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      fill_q   <= '0;
      cursor_q <= '0;
      inc_q    <= 1'b1;
      disp_q   <= 1'b0;
      ovr_q    <= 1'b0;
      aerr_q   <= 1'b0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fill_q   <= fill_d;
      cursor_q <= cursor_d;
      inc_q    <= inc_d;
      disp_q   <= disp_d;
      ovr_q    <= ovr_d;
      aerr_q   <= aerr_d;
      wcnt_q   <= wcnt_d;
    end
  end

  logic [7:0] mem_q [32];
  logic [7:0] rd_char_q;

  // NOTE: the frame buffer is built from flops on purpose: reset must blank all 32 cells at once.
  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= BLANK;
      end
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      rd_char_q <= BLANK;
    end else begin
      rd_char_q <= mem_q[{rd_row, rd_col}];
    end
  end

  assign rd_char     = rd_char_q;
  assign cursor      = cursor_q;
  assign display_on  = disp_q;
  assign busy        = (state_q != ST_IDLE);
  assign overrun     = ovr_q;
  assign addr_err    = aerr_q;
  assign write_count = wcnt_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Bench for lcd_bus_receiver: drives LCD write strobes and checks the receiver against
// a character-level model of the display (cells, cursor, flags, busy windows).
module tb_lcd_bus_receiver;

  localparam int S = 2;
  localparam int N = 50;
  localparam int C = 200;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        LCD_EN = 1'b0;
  logic        LCD_RS = 1'b0;
  logic [7:0]  LCD_DATA = 8'h00;
  logic        rd_row = 1'b0;
  logic [3:0]  rd_col = 4'h0;
  logic [7:0]  rd_char;
  logic [4:0]  cursor;
  logic        display_on;
  logic        busy;
  logic        overrun;
  logic        addr_err;
  logic [15:0] write_count;

  always #5 clk = ~clk;

  lcd_bus_receiver #(
    .SYNC_STAGES  (S),
    .BUSY_CYCLES  (N),
    .CLEAR_CYCLES (C)
  ) dut (
    .CLOCK_50    (clk),
    .Reset       (Reset),
    .LCD_EN      (LCD_EN),
    .LCD_RS      (LCD_RS),
    .LCD_DATA    (LCD_DATA),
    .rd_row      (rd_row),
    .rd_col      (rd_col),
    .rd_char     (rd_char),
    .cursor      (cursor),
    .display_on  (display_on),
    .busy        (busy),
    .overrun     (overrun),
    .addr_err    (addr_err),
    .write_count (write_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Character-level model: cell index = row*16 + col.
  logic [7:0] m_buf [32];
  int         m_cur;
  bit         m_inc, m_don, m_ovr, m_aerr;
  int         m_cnt;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
    m_cur = 0; m_inc = 1; m_don = 0; m_ovr = 0; m_aerr = 0; m_cnt = 0;
  endfunction

  function automatic void model_apply(bit rs, logic [7:0] d);
    int a;
    a = int'(d) - 128;
    if (m_cnt < 65535) m_cnt++;
    if (rs) begin
      m_buf[m_cur] = d;
      m_cur = m_inc ? (m_cur + 1) % 32 : (m_cur + 31) % 32;
    end else if (d >= 8'h80) begin
      if (a < 16) m_cur = a;
      else if (a >= 64 && a < 80) m_cur = 16 + (a - 64);
      else m_aerr = 1;
    end else if (d >= 8'h20) begin
      m_cur = m_cur;
    end else if (d >= 8'h08) begin
      m_don = d[2];
    end else if (d >= 8'h04) begin
      m_inc = d[1];
    end else if (d >= 8'h02) begin
      m_cur = 0;
    end else if (d == 8'h01) begin
      m_cur = 0; m_inc = 1;
      for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
    end
  endfunction

  // Length of the most recent completed busy run, in cycles.
  int run_len = 0;
  int last_run = 0;
  always @(negedge clk) begin
    if (busy === 1'b1) run_len++;
    else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic en_rise(bit rs, logic [7:0] d);
    @(negedge clk);
    LCD_EN = 1'b1; LCD_RS = rs; LCD_DATA = d;
  endtask

  task automatic en_fall();
    @(negedge clk);
    LCD_EN = 1'b0;
  endtask

  task automatic strobe(bit rs, logic [7:0] d);
    en_rise(rs, d);
    repeat (2) @(negedge clk);
    en_fall();
  endtask

  task automatic wait_busy_low(string tag);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < C + 100) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, want 0", tag, busy, t);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(string tag);
    repeat (S + 1) @(negedge clk);
    wait_busy_low(tag);
  endtask

  task automatic send(bit rs, logic [7:0] d);
    strobe(rs, d);
    model_apply(rs, d);
    wait_idle("send");
  endtask

  task automatic read_cell(int idx, output logic [7:0] v);
    @(negedge clk);
    rd_row = idx[4];
    rd_col = idx[3:0];
    @(negedge clk);
    v = rd_char;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    Reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (cursor !== 5'd0) begin n_bad++; $display("FAIL reset_cursor: got %h want 00", cursor); end
    n_cmp++; if (display_on !== 1'b0) begin n_bad++; $display("FAIL reset_display_on: got %b want 0", display_on); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_cmp++; if (addr_err !== 1'b0) begin n_bad++; $display("FAIL reset_addr_err: got %b want 0", addr_err); end
    n_cmp++; if (write_count !== 16'd0) begin n_bad++; $display("FAIL reset_write_count: got %h want 0000", write_count); end
    n_cmp++; if (rd_char !== 8'h20) begin n_bad++; $display("FAIL reset_rd_char: got %h want 20", rd_char); end
    @(negedge clk);
    Reset = 1'b1;
    model_reset();
    for (int i = 0; i < 32; i++) begin
      read_cell(i, v);
      n_cmp++; if (v !== 8'h20) begin n_bad++; $display("FAIL reset_cell[%0d]: got %h want 20", i, v); end
    end
  endtask

  task automatic test_basic_write();
    logic [7:0] v;
    en_rise(1'b1, 8'h61);
    repeat (2) @(negedge clk);
    en_fall();
    repeat (S) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_early: got %b want 0", busy); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_rise: got %b want 1", busy); end
    model_apply(1'b1, 8'h61);
    wait_busy_low("basic");
    n_cmp++; if (last_run !== N) begin n_bad++; $display("FAIL basic_busy_len: got %0d want %0d", last_run, N); end
    read_cell(0, v);
    n_cmp++; if (v !== m_buf[0]) begin n_bad++; $display("FAIL basic_cell0: got %h want %h", v, m_buf[0]); end
    n_cmp++; if (cursor !== 5'(m_cur)) begin n_bad++; $display("FAIL basic_cursor: got %h want %h", cursor, 5'(m_cur)); end
    n_cmp++; if (write_count !== 16'(m_cnt)) begin n_bad++; $display("FAIL basic_write_count: got %0d want %0d", write_count, m_cnt); end
  endtask

  task automatic test_addr_wrap();
    logic [7:0] v;
    send(1'b0, 8'hCF);
    send(1'b1, 8'h78);
    send(1'b1, 8'h79);
    read_cell(31, v);
    n_cmp++; if (v !== m_buf[31]) begin n_bad++; $display("FAIL wrap_cell31: got %h want %h", v, m_buf[31]); end
    read_cell(0, v);
    n_cmp++; if (v !== m_buf[0]) begin n_bad++; $display("FAIL wrap_cell0: got %h want %h", v, m_buf[0]); end
    n_cmp++; if (cursor !== 5'(m_cur)) begin n_bad++; $display("FAIL wrap_cursor: got %h want %h", cursor, 5'(m_cur)); end
  endtask

  task automatic test_clear();
    logic [7:0] v;
    logic [7:0] txt [4];
    txt = '{8'h61, 8'h62, 8'h63, 8'h64};
    send(1'b0, 8'h80);
    for (int i = 0; i < 4; i++) send(1'b1, txt[i]);
    read_cell(2, v);
    n_cmp++; if (v !== m_buf[2]) begin n_bad++; $display("FAIL clear_pre_cell2: got %h want %h", v, m_buf[2]); end
    en_rise(1'b0, 8'h01);
    repeat (2) @(negedge clk);
    en_fall();
    model_apply(1'b0, 8'h01);
    repeat (S + 1) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL clear_busy_rise: got %b want 1", busy); end
    repeat (31) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      read_cell(i, v);
      n_cmp++; if (v !== m_buf[i]) begin n_bad++; $display("FAIL clear_cell[%0d]: got %h want %h", i, v, m_buf[i]); end
    end
    n_cmp++; if (cursor !== 5'(m_cur)) begin n_bad++; $display("FAIL clear_cursor: got %h want %h", cursor, 5'(m_cur)); end
    wait_busy_low("clear");
    n_cmp++; if (last_run !== C) begin n_bad++; $display("FAIL clear_busy_len: got %0d want %0d", last_run, C); end
  endtask

  task automatic test_decrement_addr_err();
    logic [7:0] v;
    send(1'b0, 8'h04);
    send(1'b0, 8'h80);
    send(1'b1, 8'h7A);
    read_cell(0, v);
    n_cmp++; if (v !== m_buf[0]) begin n_bad++; $display("FAIL dec_cell0: got %h want %h", v, m_buf[0]); end
    n_cmp++; if (cursor !== 5'(m_cur)) begin n_bad++; $display("FAIL dec_cursor: got %h want %h", cursor, 5'(m_cur)); end
    send(1'b0, 8'hA0);
    n_cmp++; if (addr_err !== m_aerr) begin n_bad++; $display("FAIL dec_addr_err: got %b want %b", addr_err, m_aerr); end
    n_cmp++; if (cursor !== 5'(m_cur)) begin n_bad++; $display("FAIL dec_cursor_kept: got %h want %h", cursor, 5'(m_cur)); end
  endtask

  task automatic test_overrun();
    logic [7:0] v;
    int         skipped;
    en_rise(1'b1, 8'h71);
    repeat (2) @(negedge clk);
    en_fall();
    skipped = m_cur;
    model_apply(1'b1, 8'h71);
    repeat (6) @(negedge clk);
    strobe(1'b1, 8'h51);
    m_ovr = 1;
    wait_idle("overrun");
    n_cmp++; if (overrun !== m_ovr) begin n_bad++; $display("FAIL ovr_flag: got %b want %b", overrun, m_ovr); end
    n_cmp++; if (write_count !== 16'(m_cnt)) begin n_bad++; $display("FAIL ovr_write_count: got %0d want %0d", write_count, m_cnt); end
    n_cmp++; if (cursor !== 5'(m_cur)) begin n_bad++; $display("FAIL ovr_cursor: got %h want %h", cursor, 5'(m_cur)); end
    read_cell(skipped, v);
    n_cmp++; if (v !== m_buf[skipped]) begin n_bad++; $display("FAIL ovr_first_cell: got %h want %h", v, m_buf[skipped]); end
    read_cell(m_cur, v);
    n_cmp++; if (v !== m_buf[m_cur]) begin n_bad++; $display("FAIL ovr_ignored_cell: got %h want %h", v, m_buf[m_cur]); end
  endtask

  // Second strobe timed against the first one's busy window: gap 0 lands on the
  // last busy cycle, gap 1 on the first free cycle.
  task automatic timed_pair(logic [7:0] d_a, logic [7:0] d_b, int gap);
    en_rise(1'b1, d_a);
    repeat (2) @(negedge clk);
    en_fall();
    repeat (N - S - 2 + gap) @(negedge clk);
    LCD_EN = 1'b1; LCD_RS = 1'b1; LCD_DATA = d_b;
    repeat (4) @(negedge clk);
    LCD_EN = 1'b0;
  endtask

  task automatic test_busy_boundary();
    logic [7:0] v;
    @(negedge clk);
    Reset = 1'b0;
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    model_reset();
    timed_pair(8'h41, 8'h42, 0);
    model_apply(1'b1, 8'h41);
    m_ovr = 1;
    wait_idle("bound_last");
    n_cmp++; if (overrun !== m_ovr) begin n_bad++; $display("FAIL bound_last_overrun: got %b want %b", overrun, m_ovr); end
    n_cmp++; if (write_count !== 16'(m_cnt)) begin n_bad++; $display("FAIL bound_last_count: got %0d want %0d", write_count, m_cnt); end
    read_cell(1, v);
    n_cmp++; if (v !== m_buf[1]) begin n_bad++; $display("FAIL bound_last_cell1: got %h want %h", v, m_buf[1]); end
    timed_pair(8'h43, 8'h44, 1);
    model_apply(1'b1, 8'h43);
    model_apply(1'b1, 8'h44);
    wait_idle("bound_free");
    n_cmp++; if (write_count !== 16'(m_cnt)) begin n_bad++; $display("FAIL bound_free_count: got %0d want %0d", write_count, m_cnt); end
    n_cmp++; if (last_run !== N) begin n_bad++; $display("FAIL bound_free_busy_len: got %0d want %0d", last_run, N); end
    read_cell(2, v);
    n_cmp++; if (v !== m_buf[2]) begin n_bad++; $display("FAIL bound_free_cell2: got %h want %h", v, m_buf[2]); end
    n_cmp++; if (cursor !== 5'(m_cur)) begin n_bad++; $display("FAIL bound_free_cursor: got %h want %h", cursor, 5'(m_cur)); end
  endtask

  task automatic test_random();
    logic [7:0] v;
    logic [7:0] misc [7];
    logic [7:0] d;
    bit         rs;
    misc = '{8'h02, 8'h03, 8'h30, 8'h00, 8'h90, 8'hD5, 8'h01};
    for (int n = 0; n < 40; n++) begin
      rs = 1'b0;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin rs = 1'b1; d = 8'($urandom_range(32, 126)); end
        5: d = 8'h80 | 8'($urandom_range(0, 15));
        6: d = 8'hC0 | 8'($urandom_range(0, 15));
        7: d = 8'h04 | 8'($urandom_range(0, 3));
        8: d = 8'h08 | 8'($urandom_range(0, 7));
        default: d = misc[$urandom_range(0, 6)];
      endcase
      send(rs, d);
      n_cmp++; if (cursor !== 5'(m_cur)) begin n_bad++; $display("FAIL rand_cursor[%0d] rs=%b d=%h: got %h want %h", n, rs, d, cursor, 5'(m_cur)); end
    end
    for (int i = 0; i < 32; i++) begin
      read_cell(i, v);
      n_cmp++; if (v !== m_buf[i]) begin n_bad++; $display("FAIL rand_cell[%0d]: got %h want %h", i, v, m_buf[i]); end
    end
    n_cmp++; if (display_on !== m_don) begin n_bad++; $display("FAIL rand_display_on: got %b want %b", display_on, m_don); end
    n_cmp++; if (addr_err !== m_aerr) begin n_bad++; $display("FAIL rand_addr_err: got %b want %b", addr_err, m_aerr); end
    n_cmp++; if (overrun !== m_ovr) begin n_bad++; $display("FAIL rand_overrun: got %b want %b", overrun, m_ovr); end
    n_cmp++; if (write_count !== 16'(m_cnt)) begin n_bad++; $display("FAIL rand_write_count: got %0d want %0d", write_count, m_cnt); end
  endtask

  task automatic test_reset_mid_clear();
    logic [7:0] v;
    send(1'b0, 8'h0C);
    send(1'b1, 8'h61);
    en_rise(1'b0, 8'h01);
    repeat (2) @(negedge clk);
    en_fall();
    repeat (S + 1 + 100) @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midclr_busy: got %b want 0", busy); end
    n_cmp++; if (cursor !== 5'd0) begin n_bad++; $display("FAIL midclr_cursor: got %h want 00", cursor); end
    n_cmp++; if (display_on !== 1'b0) begin n_bad++; $display("FAIL midclr_display_on: got %b want 0", display_on); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL midclr_overrun: got %b want 0", overrun); end
    n_cmp++; if (addr_err !== 1'b0) begin n_bad++; $display("FAIL midclr_addr_err: got %b want 0", addr_err); end
    n_cmp++; if (write_count !== 16'd0) begin n_bad++; $display("FAIL midclr_write_count: got %0d want 0", write_count); end
    n_cmp++; if (rd_char !== 8'h20) begin n_bad++; $display("FAIL midclr_rd_char: got %h want 20", rd_char); end
    @(negedge clk);
    Reset = 1'b1;
    model_reset();
    send(1'b1, 8'h55);
    n_cmp++; if (write_count !== 16'(m_cnt)) begin n_bad++; $display("FAIL midclr_after_count: got %0d want %0d", write_count, m_cnt); end
    n_cmp++; if (last_run !== N) begin n_bad++; $display("FAIL midclr_after_busy_len: got %0d want %0d", last_run, N); end
    read_cell(0, v);
    n_cmp++; if (v !== m_buf[0]) begin n_bad++; $display("FAIL midclr_after_cell0: got %h want %h", v, m_buf[0]); end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_addr_wrap();
    test_clear();
    test_decrement_addr_err();
    test_overrun();
    test_busy_boundary();
    test_random();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
